// File: rtl/heal_executor.sv
// Heal command executor: queues correction/compensation jobs, scrubs the seat RAM
// against its golden shadow copy, and freezes bookings during compensation windows.
module heal_executor #(
    parameter int NUM_SEATS   = 16,
    parameter int SEAT_W      = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              heal_trigger,
    input  logic [1:0]        heal_mode,
    output logic              seat_rd_en,
    output logic [SEAT_W-1:0] seat_addr,
    input  logic              seat_rd_data,
    input  logic              golden_rd_data,
    output logic              seat_we,
    output logic              seat_wdata,
    output logic              hold_bookings,
    output logic              busy,
    output logic              heal_done,
    output logic [1:0]        done_mode,
    output logic [SEAT_W:0]   corrected_count,
    output logic              merge_pulse
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SEAT_W-1:0] LAST_ADDR = SEAT_W'(NUM_SEATS - 1);
    localparam logic [1:0] MODE_CORR = 2'b10;
    localparam logic [1:0] MODE_COMP = 2'b01;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN_RD  = 3'd1,
        SCAN_CMP = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_e;

    state_e             state_q;
    logic               pend_corr_q;
    logic               pend_comp_q;
    logic [SEAT_W-1:0]  addr_q;
    logic [SEAT_W:0]    count_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic               rd_en_q;
    logic               hold_q;
    logic               done_q;
    logic [1:0]         done_mode_q;
    logic [SEAT_W:0]    corr_cnt_q;
    logic               merge_q;

    logic               corr_trig_s;
    logic               comp_trig_s;
    logic               start_corr_s;
    logic               start_comp_s;
    logic               mismatch_s;
    logic [SEAT_W:0]    count_inc_s;

    assign corr_trig_s  = heal_trigger && (heal_mode == MODE_CORR);
    assign comp_trig_s  = heal_trigger && (heal_mode == MODE_COMP);
    assign start_corr_s = (state_q == IDLE) && pend_corr_q;
    assign start_comp_s = (state_q == IDLE) && !pend_corr_q && pend_comp_q;
    assign mismatch_s   = seat_rd_data ^ golden_rd_data;
    assign count_inc_s  = count_q + {{SEAT_W{1'b0}}, mismatch_s};

    // The write path is combinational in SCAN_CMP; the state reset kills it as soon as rst rises.
    assign seat_we         = (state_q == SCAN_CMP) && mismatch_s;
    assign seat_wdata      = (state_q == SCAN_CMP) && golden_rd_data;
    assign seat_rd_en      = rd_en_q;
    assign seat_addr       = addr_q;
    assign hold_bookings   = hold_q;
    assign busy            = (state_q != IDLE) || pend_corr_q || pend_comp_q;
    assign heal_done       = done_q;
    assign done_mode       = done_mode_q;
    assign corrected_count = corr_cnt_q;
    assign merge_pulse     = merge_q;

    // Job queue, scan/hold sequencing and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_corr_q <= 1'b0;
            pend_comp_q <= 1'b0;
            addr_q      <= {SEAT_W{1'b0}};
            count_q     <= {(SEAT_W+1){1'b0}};
            hold_cnt_q  <= {HOLD_W{1'b0}};
            rd_en_q     <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            done_mode_q <= 2'b00;
            corr_cnt_q  <= {(SEAT_W+1){1'b0}};
            merge_q     <= 1'b0;
        end else begin
            // A trigger landing on an already-set flag is absorbed, even on the dequeue edge.
            pend_corr_q <= (pend_corr_q && !start_corr_s) || (corr_trig_s && !pend_corr_q);
            pend_comp_q <= (pend_comp_q && !start_comp_s) || (comp_trig_s && !pend_comp_q);
            merge_q     <= (corr_trig_s && pend_corr_q) || (comp_trig_s && pend_comp_q);
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_corr_s) begin
                        addr_q  <= {SEAT_W{1'b0}};
                        count_q <= {(SEAT_W+1){1'b0}};
                        rd_en_q <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= SCAN_RD;
                    end else if (start_comp_s) begin
                        hold_cnt_q <= HOLD_LOAD;
                        hold_q     <= 1'b1;
                        state_q    <= HOLD;
                    end else begin
                        hold_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SCAN_RD: begin
                    hold_q  <= 1'b1;
                    state_q <= SCAN_CMP;
                end
                SCAN_CMP: begin
                    count_q <= count_inc_s;
                    if (addr_q == LAST_ADDR) begin
                        corr_cnt_q  <= count_inc_s;
                        done_q      <= 1'b1;
                        done_mode_q <= MODE_CORR;
                        hold_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        addr_q  <= addr_q + {{(SEAT_W-1){1'b0}}, 1'b1};
                        rd_en_q <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= SCAN_RD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == {HOLD_W{1'b0}}) begin
                        done_q      <= 1'b1;
                        done_mode_q <= MODE_COMP;
                        hold_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                        hold_q     <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                DONE: begin
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/heal_executor.md
# heal_executor

Executes the heal commands issued by the self-healing controller. Each single-cycle `heal_trigger` pulse is latched as a pending job. A seat-correction job (mode 2'b10) scans the seat-occupancy RAM against the golden shadow copy and rewrites any mismatched seat. A compensation job (mode 2'b01) freezes new bookings for a fixed window. The block sits between the controller and the seat RAM / booking front-end, and reports completion and repair statistics upstream.

## Interface
- NUM_SEATS, 16, seats in RAM (power of two, ≥2)
- SEAT_W, 4, log2(NUM_SEATS)
- HOLD_CYCLES, 8, compensation booking-freeze length (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- heal_trigger  in  1  one-cycle heal request
- heal_mode  in  2  2'b10 correction, 2'b01 compensation, others ignored
- seat_rd_en  out  1  read strobe to seat RAM and shadow RAM
- seat_addr  out  SEAT_W  seat address, registered
- seat_rd_data  in  1  live seat bit, valid one cycle after seat_rd_en
- golden_rd_data  in  1  shadow seat bit, same address/latency
- seat_we  out  1  seat RAM write enable
- seat_wdata  out  1  write data (= golden_rd_data)
- hold_bookings  out  1  booking front-end must stall new reservations
- busy  out  1  state ≠ IDLE or any job pending
- heal_done  out  1  one-cycle completion pulse
- done_mode  out  2  mode of completed job, valid with heal_done
- corrected_count  out  SEAT_W+1  seats rewritten by last correction job
- merge_pulse  out  1  one-cycle pulse: trigger merged into already-pending job

## Operation
- Pending flags: pend_corr, pend_comp. Both are set on the edge sampling `heal_trigger`=1 with the matching mode.
- Modes 2'b00 and 2'b11 are ignored: no flag is set and no pulse is produced.
- If the flag is already set, the trigger merges: `merge_pulse`=1 next cycle and no extra job is created.
- A trigger for the mode currently executing sets its flag, so the job reruns afterwards.
- FSM states: IDLE, SCAN_RD, SCAN_CMP, HOLD, DONE.
- **IDLE**: if pend_corr, clear it, set addr=0, count=0, go to SCAN_RD. Else if pend_comp, clear it, load hold counter = HOLD_CYCLES−1, go to HOLD. Correction has priority.
- **SCAN_RD**: `seat_rd_en`=1 at `seat_addr`. Next state SCAN_CMP.
- **SCAN_CMP**: `seat_we` = (seat_rd_data ≠ golden_rd_data), combinational, same address, `seat_wdata`=golden_rd_data. On mismatch, count += 1. If addr = NUM_SEATS−1, go to DONE; else addr += 1 and go to SCAN_RD.
- **HOLD**: decrement counter. At 0, go to DONE.
- **DONE**: `heal_done`=1, `done_mode` = job mode, then IDLE. `corrected_count` updates on entry to DONE for correction jobs only, and holds until the next correction DONE.
- `hold_bookings`=1 in SCAN_RD, SCAN_CMP and HOLD.
- count saturates naturally: max NUM_SEATS fits in SEAT_W+1 bits.

## Timing
- Reset (async, immediate):
  - state IDLE, pending flags 0, addr 0
  - `seat_rd_en`, `seat_we`, `seat_wdata`, `hold_bookings`, `busy`, `heal_done`, `merge_pulse` = 0
  - `done_mode` = 2'b00, `corrected_count` = 0
- Reset mid-job aborts the job without completion. No write is issued after rst rises.
- Trigger sampled at edge T: pending at T. IDLE acts at T+1 if idle.
- Correction: 2·NUM_SEATS cycles of scan; DONE entered at T+1+2·NUM_SEATS. `heal_done` high for the cycle after edge T+33 (defaults).
- Compensation: HOLD for HOLD_CYCLES cycles; DONE entered at T+1+HOLD_CYCLES.
- After DONE, one IDLE cycle always precedes the next job.
- `busy` rises in the cycle after the trigger edge. It falls only after DONE with no flags pending.
- Trigger during DONE or IDLE with a job pending follows the normal flag rules.

## Test plan
- **Reset/idle**: assert rst mid-sim, release → all outputs 0, `corrected_count`=0; trigger with mode 2'b11 → no `busy`, no `heal_done`.
- **Clean correction**: RAM = shadow, mode 2'b10 at edge T → 16 reads at addresses 0..15, `seat_we` never 1, `heal_done` with `done_mode`=2'b10 after edge T+33, `corrected_count`=0.
- **Faulty correction**: seats 3, 7, 15 flipped → exactly three `seat_we` pulses at addresses 3, 7, 15 with golden data, `corrected_count`=3, RAM matches shadow afterwards.
- **Compensation**: mode 2'b01 → `hold_bookings` high for exactly 8 cycles, `heal_done` with `done_mode`=2'b01 after edge T+9, `corrected_count` unchanged.
- **Priority/merge**: compensation and correction pending together → correction runs first, then compensation. A second correction trigger while pend_corr is set → `merge_pulse`=1 and only one extra job runs.
- **Abort**: rst asserted during scan at addr 6 → `seat_we`/`hold_bookings` drop immediately. A new correction after release rescans from address 0.
